// File: rtl/uart_xmit_arb.sv
// Round-robin sequencer sharing one UART transmitter among NREQ byte sources.
// Optional WAIT watchdog is built when UART_ARB_TIMEOUT_EN is defined.
module uart_xmit_arb #(
  parameter int NREQ        = 4,
  parameter int DW          = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_l,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    xmitH,
  output logic [DW-1:0]           xmit_dataH,
  input  logic                    xmit_doneH,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    timeout_err
);

  localparam int PW = $clog2(NREQ);

  typedef logic [PW:0] sum_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_GAP
  } state_t;

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("uart_xmit_arb: NREQ must be 2..8");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_tmo
    $error("uart_xmit_arb: TIMEOUT_CYC must be >= 2");
  end

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_gid;
  logic [NREQ-1:0] r_ready;
  logic            r_xmit;
  logic            r_wait1;
  logic [DW-1:0]   r_data;

  logic            w_gnt_vld;
  logic [PW-1:0]   w_gnt_idx;
  sum_t            w_sum;
  logic            w_done_ok;
  logic            w_tmo;

  // Scan from highest offset down so the nearest requester after r_ptr wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    for (int i = NREQ; i >= 1; i--) begin
      w_sum = sum_t'(r_ptr) + sum_t'(i);
      if (w_sum >= sum_t'(NREQ)) begin
        w_sum = w_sum - sum_t'(NREQ);
      end
      if (req_valid[w_sum[PW-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_sum[PW-1:0];
      end
    end
  end

  // A done seen in the first WAIT cycle may belong to the previous byte.
  assign w_done_ok = xmit_doneH & ~r_wait1;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);

  logic [CW-1:0] r_cnt;
  logic          r_tmo_err;

  assign w_tmo = (r_state == ST_WAIT) && !w_done_ok &&
                 (r_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      r_cnt     <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      if (r_state != ST_WAIT) begin
        r_cnt <= '0;
      end else if (!w_tmo) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_tmo) begin
        r_tmo_err <= 1'b1;
      end
    end
  end

  assign timeout_err = r_tmo_err;
`else
  assign w_tmo       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_gnt_vld) begin
          w_next = ST_START;
        end
      end
      ST_START: w_next = ST_WAIT;
      ST_WAIT: begin
        if (w_done_ok || w_tmo) begin
          w_next = ST_GAP;
        end
      end
      ST_GAP:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      r_ptr   <= PW'(NREQ - 1);
      r_gid   <= '0;
      r_ready <= '0;
      r_xmit  <= 1'b0;
      r_wait1 <= 1'b0;
      r_data  <= '0;
    end else begin
      r_ready <= '0;
      r_xmit  <= (r_state == ST_START);
      r_wait1 <= (r_state == ST_START);
      if (r_state == ST_IDLE && w_gnt_vld) begin
        r_ready <= NREQ'(1) << w_gnt_idx;
        r_data  <= req_data[DW*int'(w_gnt_idx) +: DW];
        r_gid   <= w_gnt_idx;
        r_ptr   <= w_gnt_idx;
      end
    end
  end

  assign req_ready  = r_ready;
  assign xmitH      = r_xmit;
  assign xmit_dataH = r_data;
  assign grant_id   = r_gid;
  assign busy       = (r_state != ST_IDLE);

endmodule
